// File: rtl/mips_cpu_muldiv_ctrl.sv
// mips_cpu_muldiv_ctrl: HI/LO sequencer running iterative MULT/MULTU/DIV/DIVU and MTHI/MTLO
// Ports: clk, reset (async, active-low); start/op/rs_val/rt_val request in;
//        hi_wdata/hi_we, lo_wdata/lo_we drive the HI/LO registers; busy, done status.
// Optional: MULDIV_ABORT_EN adds input abort to squash an in-flight mul/div.
module mips_cpu_muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic [WIDTH-1:0] hi_wdata,
    output logic             hi_we,
    output logic [WIDTH-1:0] lo_wdata,
    output logic             lo_we,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, WB} state_t;
    state_t state, next_state;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] b_r, hi_r, lo_r, mag_a, mag_b;
    logic is_mul, neg_hi, neg_lo, accept, kill, rs_neg, rt_neg, ge;
    logic [WIDTH:0] add_s, div_t, sub_d;
    logic [2*WIDTH-1:0] prod;
    // Pulse cycle after WB still shows busy=1 with state back in IDLE; starts there are dropped.
    assign accept = start && state == IDLE && !busy;
`ifdef MULDIV_ABORT_EN
    assign kill = abort && busy && (state == MUL || state == DIV || state == FIX);
`else
    assign kill = 1'b0;
`endif
    // Divide by zero keeps the raw dividend so the remainder comes out as rs_val unchanged.
    assign rs_neg = !op[0] && rs_val[WIDTH-1] && !(op[1] && rt_val == '0);
    assign rt_neg = !op[0] && rt_val[WIDTH-1];
    assign mag_a  = rs_neg ? -rs_val : rs_val;
    assign mag_b  = rt_neg ? -rt_val : rt_val;
    assign add_s  = {1'b0, hi_r} + {1'b0, lo_r[0] ? b_r : '0};
    assign div_t  = {hi_r, lo_r[WIDTH-1]};
    assign sub_d  = div_t - {1'b0, b_r};
    assign ge     = div_t >= {1'b0, b_r};
    assign prod   = neg_lo ? -{hi_r, lo_r} : {hi_r, lo_r};
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= next_state;
    always_comb begin
        next_state = state;
        if (kill) next_state = IDLE;
        else if (state == IDLE) next_state = (accept && !op[2]) ? (op[1] ? DIV : MUL) : IDLE;
        else if (state == MUL || state == DIV) next_state = (cnt == '0) ? FIX : state;
        else if (state == FIX) next_state = WB;
        else next_state = IDLE;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            cnt      <= '0;
            b_r      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            is_mul   <= 1'b0;
            neg_hi   <= 1'b0;
            neg_lo   <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
            hi_we    <= 1'b0;
            lo_we    <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            hi_we <= 1'b0;
            lo_we <= 1'b0;
            done  <= 1'b0;
            busy  <= next_state != IDLE || state == WB;
            if (accept && !op[2]) begin
                cnt    <= CW'(WIDTH - 1);
                is_mul <= !op[1];
                neg_lo <= rs_neg ^ rt_neg;
                neg_hi <= rs_neg;
                hi_r   <= '0;
                lo_r   <= op[1] ? mag_a : mag_b;
                b_r    <= op[1] ? mag_b : mag_a;
            end
            if (accept && op == 3'd4) begin
                hi_we    <= 1'b1;
                hi_wdata <= rs_val;
                done     <= 1'b1;
            end
            if (accept && op == 3'd5) begin
                lo_we    <= 1'b1;
                lo_wdata <= rs_val;
                done     <= 1'b1;
            end
            if (state == MUL || state == DIV) cnt <= cnt - 1'b1;
            // Shift-add: low half starts as the multiplier and fills with product bits.
            if (state == MUL) begin
                hi_r <= add_s[WIDTH:1];
                lo_r <= {add_s[0], lo_r[WIDTH-1:1]};
            end
            // Restoring divide: low half starts as the dividend and fills with quotient bits.
            if (state == DIV) begin
                hi_r <= ge ? sub_d[WIDTH-1:0] : div_t[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], ge};
            end
            if (state == FIX) begin
                hi_r <= is_mul ? prod[2*WIDTH-1:WIDTH] : (neg_hi ? -hi_r : hi_r);
                lo_r <= is_mul ? prod[WIDTH-1:0] : (neg_lo ? -lo_r : lo_r);
            end
            if (state == WB) begin
                hi_we    <= 1'b1;
                lo_we    <= 1'b1;
                done     <= 1'b1;
                hi_wdata <= hi_r;
                lo_wdata <= lo_r;
            end
        end
endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// tb_mips_cpu_muldiv_ctrl: randomized self-checking bench for mips_cpu_muldiv_ctrl
module tb_mips_cpu_muldiv_ctrl;
    localparam int W = 32;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [2:0] op = '0;
    logic [W-1:0] rs_val = '0, rt_val = '0;
`ifdef MULDIV_ABORT_EN
    logic abort = 1'b0;
`endif
    logic [W-1:0] hi_wdata, lo_wdata;
    logic hi_we, lo_we, busy, done;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    logic [W-1:0] hi_m = '0, lo_m = '0;
    mips_cpu_muldiv_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
`ifdef MULDIV_ABORT_EN
        .abort(abort),
`endif
        .hi_wdata(hi_wdata), .hi_we(hi_we), .lo_wdata(lo_wdata), .lo_we(lo_we),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (hi_we || lo_we) we_cnt++;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb;
        logic [63:0] p;
        int ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ia = a;
        ib = b;
        h = '0;
        l = '0;
        if (o == 3'd0) begin
            p = sa * sb;
            {h, l} = p;
        end else if (o == 3'd1) begin
            p = {32'b0, a} * {32'b0, b};
            {h, l} = p;
        end else if (b == '0) begin
            l = '1;
            h = a;
        end else if (o == 3'd2 && a == 32'h8000_0000 && b == '1) begin
            l = 32'h8000_0000;
            h = '0;
        end else if (o == 3'd2) begin
            l = ia / ib;
            h = ia % ib;
        end else begin
            l = a / b;
            h = a % b;
        end
    endfunction
    task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit spur);
        logic [W-1:0] eh, el;
        int k, w0;
        model(o, a, b, eh, el);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); rs_val = $urandom; rt_val = $urandom;
        if (o == 3'd4 || o == 3'd5) begin
            if (o == 3'd4) hi_m = a; else lo_m = a;
            check("mt_we", {hi_we, lo_we, done, busy}, {o == 3'd4, o == 3'd5, 1'b1, 1'b0});
            check("mt_data", {hi_wdata, lo_wdata}, {hi_m, lo_m});
            @(posedge clk); #1;
            check("mt_after", {hi_we, lo_we, done, busy}, 4'b0);
        end else if (o >= 3'd6) begin
            check("nop_out", {hi_we, lo_we, done, busy}, 4'b0);
            check("nop_hold", {hi_wdata, lo_wdata}, {hi_m, lo_m});
        end else begin
            check("busy_start", busy, 1'b1);
            w0 = we_cnt;
            k = 0;
            while (!done && k < W + 10) begin
                if (spur && k == 5) begin
                    start = 1'b1; op = 3'($urandom_range(0, 5));
                end
                @(posedge clk); #1;
                start = 1'b0;
                k++;
            end
            hi_m = eh;
            lo_m = el;
            check($sformatf("lat_op%0d", o), k, W + 2);
            check($sformatf("res_op%0d", o), {hi_wdata, lo_wdata}, {eh, el});
            check("wb_flags", {hi_we, lo_we, busy}, 3'b111);
            if (spur) begin
                start = 1'b1; op = 3'd4; rs_val = ~eh;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("wb_after", {hi_we, lo_we, done, busy}, 4'b0);
            check("one_pulse", we_cnt - w0, 1);
        end
    endtask
    initial begin
        logic [W-1:0] pool [8];
        int w0;
        pool = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h2, 32'hFFFF_FFF9, 32'h3};
        #12;
        check("rst_out", {hi_we, lo_we, done, busy}, 4'b0);
        check("rst_data", {hi_wdata, lo_wdata}, 64'h0);
        @(negedge clk); reset = 1'b1;
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd0, 1'b0);
        run_op(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        run_op(3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
        run_op(3'd6, 32'h5555_5555, 32'd1, 1'b0);
        run_op(3'd0, 32'd100, 32'hFFFF_FFF6, 1'b1);
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] a, b;
            a = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 7)] : $urandom;
            b = $urandom_range(0, 3) == 0 ? pool[$urandom_range(0, 7)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
            run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        start = 1'b1; op = 3'd2; rs_val = 32'hFFFF_FFF9; rt_val = 32'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("arst_out", {hi_we, lo_we, done, busy}, 4'b0);
        check("arst_data", {hi_wdata, lo_wdata}, 64'h0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk); reset = 1'b1;
        w0 = we_cnt;
        repeat (W + 5) @(posedge clk);
        #1;
        check("arst_nowr", we_cnt - w0, 0);
        run_op(3'd1, 32'd3, 32'd4, 1'b0);
`ifdef MULDIV_ABORT_EN
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_val = 32'd9; rt_val = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        w0 = we_cnt;
        repeat (W + 5) begin
            @(posedge clk); #1;
            if (done) check("abort_done", done, 1'b0);
        end
        check("abort_nowr", we_cnt - w0, 0);
        run_op(3'd5, 32'hA5A5_0001, 32'd0, 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
